// File: rtl/dp_mem_responder.sv
// dp_mem_responder: arbitrates datapath fetch/data requests onto a single-ported RAM,
// returning registered one-cycle ihit/dhit pulses; a watchdog abandons stuck accesses.
`default_nettype none

module dp_mem_responder #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] BAD_WORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        fault
);

  localparam logic [1:0]  c_RAM_ACCESS = 2'd2;
  localparam logic [15:0] c_CNT_LAST   = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DACC = 2'd1,
    ST_IACC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [29:0] r_addr;
  logic [31:0] r_store;
  logic        r_wr;
  logic [15:0] r_cnt;
  logic        r_ihit;
  logic        r_dhit;
  logic [31:0] r_imemload;
  logic [31:0] r_dmemload;
  logic        r_fault;

  logic        w_in_acc;
  logic        w_access;
  logic        w_tout;
  logic        w_dreq;
  logic        w_unused_lo;

  // Word alignment discards the byte offset of both request addresses.
  assign w_unused_lo = ^{imemaddr[1:0], dmemaddr[1:0]};

  assign w_in_acc = (r_state == ST_DACC) || (r_state == ST_IACC);
  assign w_access = (ramstate == c_RAM_ACCESS);
  // Counter equals cycles already spent, so this is the TIMEOUT-th access cycle.
  assign w_tout   = w_in_acc && !w_access && (r_cnt == c_CNT_LAST);
  assign w_dreq   = dmemWEN || dmemREN;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_dreq)       w_next = ST_DACC;
        else if (imemREN) w_next = ST_IACC;
      end
      ST_DACC, ST_IACC: begin
        if (w_access || w_tout) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_store    <= '0;
      r_wr       <= 1'b0;
      r_cnt      <= '0;
      r_ihit     <= 1'b0;
      r_dhit     <= 1'b0;
      r_imemload <= '0;
      r_dmemload <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ihit  <= (r_state == ST_IACC) && (w_next == ST_DONE);
      r_dhit  <= (r_state == ST_DACC) && (w_next == ST_DONE);

      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
        if (w_dreq) begin
          r_addr  <= dmemaddr[31:2];
          r_store <= dmemstore;
          r_wr    <= dmemWEN;
        end else if (imemREN) begin
          r_addr <= imemaddr[31:2];
          r_wr   <= 1'b0;
        end
      end else if (w_in_acc) begin
        r_cnt <= r_cnt + 16'd1;
      end

      if (r_state == ST_IACC) begin
        if (w_access)    r_imemload <= ramload;
        else if (w_tout) r_imemload <= BAD_WORD;
      end
      if ((r_state == ST_DACC) && !r_wr) begin
        if (w_access)    r_dmemload <= ramload;
        else if (w_tout) r_dmemload <= BAD_WORD;
      end

      if (w_tout) r_fault <= 1'b1;
    end
  end

  assign ramREN   = w_in_acc && !((r_state == ST_DACC) && r_wr);
  assign ramWEN   = (r_state == ST_DACC) && r_wr;
  assign ramaddr  = {r_addr, 2'b00};
  assign ramstore = r_store;

  assign ihit     = r_ihit;
  assign dhit     = r_dhit;
  assign imemload = r_imemload;
  assign dmemload = r_dmemload;
  assign fault    = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_dp_mem_responder.sv
// tb_dp_mem_responder: directed vectors with hand-computed expectations for dp_mem_responder.
`default_nettype none

module tb_dp_mem_responder;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        ihit;
  logic [31:0] imemload;
  logic        dhit;
  logic [31:0] dmemload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  dp_mem_responder #(.TIMEOUT(8), .BAD_WORD(32'hBAD1BAD1)) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .ihit      (ihit),
    .imemload  (imemload),
    .dhit      (dhit),
    .dmemload  (dmemload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .fault     (fault)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; imemREN = 0; imemaddr = '0; dmemREN = 0; dmemWEN = 0;
    dmemaddr = '0; dmemstore = '0; ramload = '0; ramstate = RS_FREE;
    step(); step();
    check_eq("rst_ramREN",   {31'd0, ramREN}, 32'd0);
    check_eq("rst_ramWEN",   {31'd0, ramWEN}, 32'd0);
    check_eq("rst_ramaddr",  ramaddr, 32'd0);
    check_eq("rst_ramstore", ramstore, 32'd0);
    check_eq("rst_hits",     {30'd0, ihit, dhit}, 32'd0);
    check_eq("rst_imemload", imemload, 32'd0);
    check_eq("rst_dmemload", dmemload, 32'd0);
    check_eq("rst_fault",    {31'd0, fault}, 32'd0);
    RST = 1'b0;

    // Zero-wait fetch
    imemREN = 1; imemaddr = 32'h44;
    step();
    check_eq("f_ramREN",  {31'd0, ramREN}, 32'd1);
    check_eq("f_ramaddr", ramaddr, 32'h44);
    check_eq("f_ihit_c1", {31'd0, ihit}, 32'd0);
    ramstate = RS_ACCESS; ramload = 32'h8C220004;
    step();
    check_eq("f_ihit_c2",  {31'd0, ihit}, 32'd1);
    check_eq("f_imemload", imemload, 32'h8C220004);
    check_eq("f_ramREN_d", {31'd0, ramREN}, 32'd0);
    imemREN = 0; ramstate = RS_FREE; ramload = 32'h0;
    step();
    check_eq("f_ihit_c3", {31'd0, ihit}, 32'd0);
    check_eq("f_hold",    imemload, 32'h8C220004);

    // Fetch and load together: data first, fetch hit 3 cycles after dhit
    imemREN = 1; imemaddr = 32'h100; dmemREN = 1; dmemaddr = 32'h203;
    ramstate = RS_ACCESS; ramload = 32'h55AA;
    step();
    check_eq("fl_ramaddr", ramaddr, 32'h200);
    check_eq("fl_ramREN",  {31'd0, ramREN}, 32'd1);
    step();
    check_eq("fl_hits_c2", {30'd0, ihit, dhit}, 32'd1);
    check_eq("fl_dmemload", dmemload, 32'h55AA);
    dmemREN = 0; ramload = 32'h1111;
    step();
    check_eq("fl_idle", {29'd0, ramREN, ihit, dhit}, 32'd0);
    step();
    check_eq("fl_iaddr", ramaddr, 32'h100);
    check_eq("fl_iREN",  {31'd0, ramREN}, 32'd1);
    step();
    check_eq("fl_hits_c5", {30'd0, ihit, dhit}, 32'd2);
    check_eq("fl_imemload", imemload, 32'h1111);
    imemREN = 0; ramstate = RS_FREE;
    step();

    // Write (with read also asserted) under BUSY x4 then ACCESS
    dmemWEN = 1; dmemREN = 1; dmemaddr = 32'h302; dmemstore = 32'hDEADBEEF;
    ramstate = RS_BUSY; ramload = 32'hFFFF0000;
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("w_ramWEN_%0d", i), {31'd0, ramWEN}, 32'd1);
      check_eq($sformatf("w_ramREN_%0d", i), {31'd0, ramREN}, 32'd0);
      check_eq($sformatf("w_store_%0d", i), ramstore, 32'hDEADBEEF);
      check_eq($sformatf("w_dhit_%0d", i), {31'd0, dhit}, 32'd0);
      step();
    end
    check_eq("w_ramWEN_4", {31'd0, ramWEN}, 32'd1);
    check_eq("w_ramaddr",  ramaddr, 32'h300);
    ramstate = RS_ACCESS;
    step();
    check_eq("w_dhit",     {31'd0, dhit}, 32'd1);
    check_eq("w_dmemload", dmemload, 32'h55AA);
    check_eq("w_ramWEN_d", {31'd0, ramWEN}, 32'd0);
    dmemWEN = 0; dmemREN = 0; ramstate = RS_FREE;
    step();
    check_eq("w_dhit_off", {31'd0, dhit}, 32'd0);

    // ERROR twice, then ACCESS
    dmemREN = 1; dmemaddr = 32'h400; ramstate = RS_ERROR;
    step();
    check_eq("e_ramREN_1", {31'd0, ramREN}, 32'd1);
    check_eq("e_dhit_1",   {31'd0, dhit}, 32'd0);
    step();
    check_eq("e_ramREN_2", {31'd0, ramREN}, 32'd1);
    check_eq("e_dhit_2",   {31'd0, dhit}, 32'd0);
    ramstate = RS_ACCESS; ramload = 32'h1234;
    step();
    check_eq("e_dhit",     {31'd0, dhit}, 32'd1);
    check_eq("e_dmemload", dmemload, 32'h1234);
    check_eq("e_fault",    {31'd0, fault}, 32'd0);
    dmemREN = 0; ramstate = RS_FREE;
    step();

    // Timeout with RAM stuck BUSY (TIMEOUT=8)
    dmemREN = 1; dmemaddr = 32'h500; ramstate = RS_BUSY; ramload = 32'h9999;
    step();
    for (int i = 1; i <= 8; i++) begin
      check_eq($sformatf("t_ramREN_%0d", i), {31'd0, ramREN}, 32'd1);
      check_eq($sformatf("t_dhit_%0d", i), {31'd0, dhit}, 32'd0);
      step();
    end
    check_eq("t_dhit_9",   {31'd0, dhit}, 32'd1);
    check_eq("t_dmemload", dmemload, 32'hBAD1BAD1);
    check_eq("t_fault",    {31'd0, fault}, 32'd1);
    check_eq("t_ramREN_9", {31'd0, ramREN}, 32'd0);
    dmemREN = 0; ramstate = RS_FREE;
    step();
    imemREN = 1; imemaddr = 32'h80; ramstate = RS_ACCESS; ramload = 32'hCAFE;
    step(); step();
    check_eq("t_after_ihit",  {31'd0, ihit}, 32'd1);
    check_eq("t_after_load",  imemload, 32'hCAFE);
    check_eq("t_fault_stick", {31'd0, fault}, 32'd1);
    imemREN = 0; ramstate = RS_FREE;
    step();

    // Reset mid-access, request held across reset
    dmemREN = 1; dmemaddr = 32'h600; ramstate = RS_BUSY;
    step();
    check_eq("r_ramREN_pre", {31'd0, ramREN}, 32'd1);
    #2 RST = 1'b1;
    #1;
    check_eq("r_ramREN_async", {31'd0, ramREN}, 32'd0);
    check_eq("r_fault_clr",    {31'd0, fault}, 32'd0);
    ramstate = RS_ACCESS; ramload = 32'h7777;
    step();
    check_eq("r_dhit_rst", {31'd0, dhit}, 32'd0);
    RST = 1'b0;
    step();
    check_eq("r_ramREN_post", {31'd0, ramREN}, 32'd1);
    check_eq("r_ramaddr",     ramaddr, 32'h600);
    step();
    check_eq("r_dhit",     {31'd0, dhit}, 32'd1);
    check_eq("r_dmemload", dmemload, 32'h7777);
    dmemREN = 0; ramstate = RS_FREE;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dp_mem_responder.md
# dp_mem_responder

Memory-side responder for the datapath/cache request interface: accepts the datapath's level-held instruction and data requests, arbitrates them onto a single-ported RAM, and returns one-cycle `ihit`/`dhit` pulses with registered load data. It sits between the datapath and RAM, in place of the caches, for single-cycle and early pipeline bring-up. Data requests take priority over instruction fetches, and a watchdog flags RAM accesses that never complete.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles spent in an access state before the access is abandoned; range 1..65535.
- `BAD_WORD`, 32'hBAD1BAD1: load value returned on a timed-out read.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `imemREN`  in  1  instruction fetch request, held until `ihit`.
- `imemaddr`  in  32  fetch address.
- `dmemREN`  in  1  data read request, held until `dhit`.
- `dmemWEN`  in  1  data write request, held until `dhit`.
- `dmemaddr`  in  32  data address.
- `dmemstore`  in  32  write data.
- `ihit`  out  1  one-cycle fetch-complete pulse.
- `imemload`  out  32  fetched word; valid while `ihit`=1, held until the next fetch completes.
- `dhit`  out  1  one-cycle data-complete pulse, for both reads and writes.
- `dmemload`  out  32  read word; valid while `dhit`=1 after a read, held otherwise.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM word address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data, valid when `ramstate`=ACCESS.
- `ramstate`  in  2  RAM status encoding: 0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR.
- `fault`  out  1  sticky; set by a timeout, cleared only by `RST`.

## Operation
- FSM states: IDLE, DACC, IACC, DONE.
- IDLE:
  - If `dmemWEN` or `dmemREN` is high, capture the address, store data and operation, then go to DACC.
  - Otherwise, if `imemREN` is high, capture `imemaddr` and go to IACC.
  - Otherwise stay in IDLE.
- Operation precedence: write beats read, and data beats fetch.
- If `dmemWEN` and `dmemREN` are both high, the request is a write. The read is not performed.
- DACC and IACC:
  - Drive `ramaddr` = {captured[31:2], 2'b00}.
  - Drive `ramREN`, or `ramWEN` with `ramstore` = captured store data.
  - On `ramstate`=ACCESS, capture `ramload` into the matching load register (reads only) and go to DONE.
  - BUSY and FREE: stay in the access state.
  - ERROR: stay in the access state and re-issue the access. ERROR is not a completion.
- Watchdog:
  - A 16-bit counter clears on entry to DACC/IACC and increments each cycle spent in those states.
  - When the counter reaches `TIMEOUT` without ACCESS, set `fault` and go to DONE.
  - A timed-out read loads `BAD_WORD`. A timed-out write is dropped.
- DONE:
  - RAM enables are low.
  - Assert exactly one of `ihit`/`dhit`, matching the completed request, for one cycle.
  - Go to IDLE unconditionally.
- Requests are re-sampled only in IDLE. Request changes during DACC, IACC or DONE are ignored.
- `ramREN`/`ramWEN` are high only in DACC/IACC, and never both at once.

## Timing
- Reset:
  - `RST` high forces IDLE immediately, without waiting for a clock edge.
  - The following outputs go to 0: `ihit`, `dhit`, `ramREN`, `ramWEN`, `ramaddr`, `ramstore`, `imemload`, `dmemload`, `fault`, and the counter.
  - Reset during DACC or IACC abandons the access with no hit. The first request after reset release is sampled at the first rising edge with `RST` low.
- Latency:
  - Request seen in IDLE at edge 0 → RAM enable high in cycle 1.
  - ACCESS seen at edge N → hit high in cycle N+1, then IDLE in cycle N+2.
  - With a zero-wait RAM (ACCESS in the first access cycle), the request-to-hit latency is 2 cycles and the repeat rate is one request per 3 cycles.
- `ihit`, `dhit`, `imemload` and `dmemload` are registered outputs with no combinational path from any input.
- The requester drops or changes its request on the edge that ends the DONE cycle. IDLE then samples the new values, so no request is served twice.
- Simultaneous fetch and data request in IDLE: the data request is served first; the fetch starts in the IDLE cycle after the `dhit`.
- A timeout hit occurs `TIMEOUT`+1 cycles after entry to the access state.

## Test plan
- Zero-wait fetch: `imemREN`=1, `imemaddr`=0x00000044, RAM returns ACCESS with `ramload`=0x8C220004 → `ramaddr`=0x44 one cycle later; `ihit`=1 for one cycle with `imemload`=0x8C220004; latency 2.
- Fetch and load together: `imemREN`=1 and `dmemREN`=1 with `dmemaddr`=0x203 → first RAM access is `ramaddr`=0x200 with `dhit`; the fetch follows; `ihit` arrives 3 cycles after `dhit`.
- Write with RAM BUSY for 4 cycles, then ACCESS: `dmemWEN`=1, `dmemstore`=0xDEADBEEF → `ramWEN` held for 5 cycles with `ramstore` stable; `dhit` pulses once; `dmemload` is unchanged.
- ERROR then ACCESS: read sees ERROR for 2 cycles, then ACCESS with 0x1234 → access re-issued with no hit during ERROR; `dmemload`=0x1234; `fault`=0.
- Timeout: with `TIMEOUT`=8 and RAM stuck BUSY, a read → `dhit` at cycle 9 of the access with `dmemload`=0xBAD1BAD1; `fault`=1 and stays 1 through later successful accesses.
- Reset mid-access: `RST` asserted while in DACC → `ramREN`=0 immediately with no `dhit`; a request held after reset release is served normally.
